// File: rtl/fib_seq_gen.sv
// Iterative generalised Fibonacci generator: F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2).
// One addition per clock; result is F(i) mod 2^W with a sticky overflow flag.
module fib_seq_gen #(
  parameter int W  = 20,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [IW-1:0] i,
  input  logic [W-1:0]  seed0,
  input  logic [W-1:0]  seed1,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  b_reg, b_next;
  logic [IW-1:0] cnt_reg, cnt_next;
  logic          oa_reg, oa_next;
  logic          ob_reg, ob_next;
  logic [W-1:0]  result_reg, result_next;
  logic          overflow_reg, overflow_next;
  logic [W:0]    sum;

  // oa/ob track whether the term held in a/b has ever exceeded W bits.
  assign sum = {1'b0, a_reg} + {1'b0, b_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      cnt_reg      <= '0;
      oa_reg       <= 1'b0;
      ob_reg       <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      cnt_reg      <= cnt_next;
      oa_reg       <= oa_next;
      ob_reg       <= ob_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    cnt_next      = cnt_reg;
    oa_next       = oa_reg;
    ob_next       = ob_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = seed0;
          b_next     = seed1;
          cnt_next   = i;
          oa_next    = 1'b0;
          ob_next    = 1'b0;
          state_next = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          a_next   = b_reg;
          b_next   = sum[W-1:0];
          oa_next  = ob_reg;
          ob_next  = oa_reg | ob_reg | sum[W];
          cnt_next = cnt_reg - 1'b1;
        end else begin
          // Only a's flag is published; b already holds F(i+1).
          result_next   = a_reg;
          overflow_next = oa_reg;
          state_next    = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == FIN);
  assign result   = result_reg;
  assign overflow = overflow_reg;

endmodule

// File: doc/fib_seq_gen.md
FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 SHALL have parameter W, default 20: width of seeds and result.
REQ-002 SHALL have parameter IW, default 5: width of index i.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-005 SHALL have port start  input  1  request a new computation; sampled on the rising edge of clk.
REQ-006 SHALL have port abort  input  1  cancel the computation in progress.
REQ-007 SHALL have port i  input  IW  sequence index, sampled with an accepted start.
REQ-008 SHALL have port seed0  input  W  term F(0), sampled with an accepted start.
REQ-009 SHALL have port seed1  input  W  term F(1), sampled with an accepted start.
REQ-010 SHALL have port busy  output  1  high while a computation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port result  output  W  F(i) modulo 2^W.
REQ-013 SHALL have port overflow  output  1  F(i) exceeded 2^W-1.

Function
REQ-014 SHALL compute the generalised sequence F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2).
REQ-015 SHALL implement FSM states IDLE, CALC and FIN, with IDLE as the reset state.
REQ-016 IDLE: start=1 at a rising edge SHALL be accepted: a<=seed0, b<=seed1, cnt<=i, oa<=0, ob<=0, state CALC.
REQ-017 CALC with cnt!=0 SHALL, on each edge, perform: a<=b; b<=(a+b) mod 2^W; oa<=ob; ob<=oa|ob|carry(a+b); cnt<=cnt-1.
REQ-018 CALC with cnt==0 SHALL, on the next edge, perform: result<=a; overflow<=oa; state FIN.
REQ-019 FIN SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-020 done SHALL be decoded from state FIN and SHALL be high for exactly one cycle per completed computation.
REQ-021 Latency: done SHALL be high in the cycle beginning i+1 rising edges after the start-accepting edge (i=0 gives 1 edge).
REQ-022 busy SHALL be 1 in CALC and FIN, and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored, with no queuing and no effect on the computation in progress.
REQ-024 start SHALL be accepted in the IDLE cycle that immediately follows FIN.
REQ-025 result and overflow SHALL update only on the edge entering FIN, and SHALL hold until the next FIN.
REQ-026 result and overflow SHALL NOT change on an accepted start.
REQ-027 Changes on i, seed0 and seed1 after the accepting edge SHALL NOT affect the computation in progress.
REQ-028 abort=1 at an edge in CALC SHALL return the FSM to IDLE with no done pulse, leaving result and overflow unchanged.
REQ-029 abort SHALL take priority over the REQ-018 FIN transition.
REQ-030 abort in IDLE or FIN SHALL have no effect.
REQ-031 abort and start together in IDLE SHALL accept the start.
REQ-032 The adder SHALL be W+1 bits wide; the carry bit feeds ob, and stored terms are truncated to W bits.
REQ-033 overflow SHALL reflect only terms up to F(i); overflow of F(i+1), computed internally, SHALL NOT set it.

Reset
REQ-034 rst=0 SHALL asynchronously clear state to IDLE, and a, b, cnt, oa, ob, result and overflow to 0.
REQ-035 While rst=0, busy and done SHALL be 0.
REQ-036 Reset asserted mid-CALC SHALL discard the computation, with no done pulse after release.
REQ-037 After rst returns to 1, the first rising edge SHALL accept a start.

Verification
REQ-038 W=20, seeds 0/1, i=10 -> done high 11 edges after the accepting edge; result=55; overflow=0.
REQ-039 Seeds 0/1, i=30 -> result=832040, overflow=0; then i=31 -> result=297693 (1346269 mod 2^20), overflow=1.
REQ-040 Seeds 2/1 (Lucas), i=10 -> result=123; then i=0 -> result=2 with done 1 edge after accept; i=1 -> result=1.
REQ-041 start pulsed with i=5 during a busy i=20 run -> single done, result=6765; the second start SHALL be ignored.
REQ-042 abort raised 3 cycles into an i=20 run -> no done, busy=0, result keeps its previous value (55); a following start with i=7 -> result=13.
REQ-043 rst=0 mid-run at i=25 -> busy, done, result and overflow all 0 immediately; after release, i=25 -> result=75025.
